// File: rtl/tdm_slot_mux.sv
// tdm_slot_mux: time-division multiplexer of NCH one-word channel buffers onto a shared slot bus.
// Latency: registered output; a word accepted at edge k can appear at edge k+1 at best, 2*NCH-1 enabled cycles at worst.
// Backpressure: in_ready[i] = ~full[i]; the bus emits one word (real or LFSR filler) per en=1 cycle and freezes when en=0.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   en              slot advance enable; low freezes slot/offset/LFSR and drops out_valid
//   in_valid/in_ready/in_data   per-channel handshake; channel i uses in_data[i*W +: W]
//   out_valid       a slot decision was made on the last edge
//   out_data        buffered word or LFSR filler
//   out_ch          channel owning this slot
//   out_real        1 = out_data came from a channel buffer
//   out_sof         first slot of a frame
module tdm_slot_mux #(
  parameter int          NCH  = 4,
  parameter int          W    = 8,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NCH-1:0]           in_valid,
  input  logic [NCH*W-1:0]         in_data,
  output logic [NCH-1:0]           in_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic [$clog2(NCH)-1:0]   out_ch,
  output logic                     out_real,
  output logic                     out_sof
);

  localparam int             CW       = $clog2(NCH);
  localparam logic [CW-1:0]  LAST     = CW'(NCH - 1);
  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0]    SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  logic [CW-1:0]  slot_q, slot_d;
  logic [CW-1:0]  off_q, off_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [15:0]    lfsr_n;
  logic [NCH-1:0] full_q, full_d;
  logic [W-1:0]   data_buf_q [NCH];
  logic [W-1:0]   data_buf_d [NCH];
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]  out_ch_q, out_ch_d;
  logic           out_real_q, out_real_d;
  logic           out_sof_q, out_sof_d;
  logic [CW-1:0]  sel;

  // x^16+x^14+x^13+x^11+1 Fibonacci step
  assign lfsr_n = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Channel served this slot; the CW-bit sum wraps naturally because NCH is a power of two.
  assign sel = slot_q + off_q;

  always_comb begin
    slot_d      = slot_q;
    off_d       = off_q;
    lfsr_d      = lfsr_q;
    full_d      = full_q;
    data_buf_d  = data_buf_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_real_d  = out_real_q;
    out_sof_d   = out_sof_q;

    // Accepts run regardless of en. A full channel is never accepting, so the
    // drain below can never collide with an accept on the same channel.
    for (int i = 0; i < NCH; i++) begin
      if (in_valid[i] && !full_q[i]) begin
        full_d[i]     = 1'b1;
        data_buf_d[i] = in_data[i*W +: W];
      end
    end

    if (en) begin
      out_valid_d = 1'b1;
      out_ch_d    = sel;
      out_sof_d   = (slot_q == '0);
      if (full_q[sel]) begin
        out_data_d  = data_buf_q[sel];
        out_real_d  = 1'b1;
        full_d[sel] = 1'b0;
      end else begin
        out_data_d  = lfsr_q[W-1:0];
        out_real_d  = 1'b0;
      end
      slot_d = slot_q + CW'(1);
      // Offset and filler source change only at frame boundaries.
      if (slot_q == LAST) begin
        lfsr_d = lfsr_n;
        off_d  = lfsr_n[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= '0;
      off_q       <= '0;
      lfsr_q      <= SEED_EFF;
      full_q      <= '0;
      data_buf_q  <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_real_q  <= 1'b0;
      out_sof_q   <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      off_q       <= off_d;
      lfsr_q      <= lfsr_d;
      full_q      <= full_d;
      data_buf_q  <= data_buf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_real_q  <= out_real_d;
      out_sof_q   <= out_sof_d;
    end
  end

  assign in_ready  = ~full_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_real  = out_real_q;
  assign out_sof   = out_sof_q;

endmodule
